wb_native_bridge: RTL and testbench



---
 rtl/wb_native_bridge_pkg.sv | 15 +
 rtl/wb_native_bridge_timeout_counter.sv | 39 +++
 rtl/wb_native_bridge.sv | 148 ++++++++++++++
 tb/tb_wb_native_bridge.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_native_bridge_pkg.sv
// Shared definitions for the Wishbone-to-native bridge: FSM state encoding
// and the default address window / error-data constants.
package wb_native_bridge_pkg;

    typedef logic [1:0] bridge_state_t;

    localparam bridge_state_t ST_IDLE = 2'd0;
    localparam bridge_state_t ST_REQ  = 2'd1;
    localparam bridge_state_t ST_COOL = 2'd2;

    localparam logic [31:0] DEF_ADDR_BASE = 32'h3000_0000;
    localparam logic [31:0] DEF_ADDR_MASK = 32'hFFF0_0000;
    localparam logic [31:0] DEF_ERR_DATA  = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_native_bridge_timeout_counter.sv
// Saturating cycle counter for the bridge's request timeout; tc_o pulses on
// the enabled cycle in which the count sits at TIMEOUT_CYCLES-1.
module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && !clr_i && (cnt_q == CNT_TC);

endmodule

// File: rtl/wb_native_bridge.sv
// Wishbone classic slave that turns an in-window cycle into a native
// valid/ready/wstrb request and returns a single-cycle ack, with a timeout.
module wb_native_bridge
    import wb_native_bridge_pkg::*;
#(
    parameter int                       WORD_SIZE      = 32,
    parameter int                       WHISBONE_ADR   = 32,
    parameter logic [WHISBONE_ADR-1:0]  ADDR_BASE      = WHISBONE_ADR'(DEF_ADDR_BASE),
    parameter logic [WHISBONE_ADR-1:0]  ADDR_MASK      = WHISBONE_ADR'(DEF_ADDR_MASK),
    parameter int                       TIMEOUT_CYCLES = 16,
    parameter logic [WORD_SIZE-1:0]     ERR_DATA       = WORD_SIZE'(DEF_ERR_DATA)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [WHISBONE_ADR-1:0] wbs_adr_i,
    input  logic [WORD_SIZE-1:0]    wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [WORD_SIZE-1:0]    wbs_dat_o,
    output logic                    valid_o,
    output logic                    wbs_we_o,
    output logic [3:0]              wstrb_o,
    output logic [WORD_SIZE-1:0]    wdata_o,
    output logic [WHISBONE_ADR-1:0] adr_o,
    input  logic                    ready_i,
    input  logic [WORD_SIZE-1:0]    rdata_i,
    output logic                    timeout_o
);

    bridge_state_t           state_q,   state_d;
    logic                    valid_q,   valid_d;
    logic                    we_q,      we_d;
    logic [3:0]              wstrb_q,   wstrb_d;
    logic [WORD_SIZE-1:0]    wdata_q,   wdata_d;
    logic [WHISBONE_ADR-1:0] adr_q,     adr_d;
    logic                    ack_q,     ack_d;
    logic [WORD_SIZE-1:0]    dat_q,     dat_d;
    logic                    timeout_q, timeout_d;

    logic in_window;
    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;

    assign in_window = ((wbs_adr_i & ADDR_MASK) == ADDR_BASE);

    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        we_d      = we_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        adr_d     = adr_q;
        ack_d     = 1'b0;
        dat_d     = dat_q;
        timeout_d = timeout_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Out-of-window cycles belong to another slave and are left alone.
                if (wbs_cyc_i && wbs_stb_i && in_window) begin
                    adr_d   = wbs_adr_i;
                    we_d    = wbs_we_i;
                    wstrb_d = wbs_we_i ? wbs_sel_i : 4'b0000;
                    wdata_d = wbs_dat_i;
                    valid_d = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_en = 1'b1;
                // A master abort outranks a same-cycle ready: no ack is owed.
                if (!wbs_cyc_i) begin
                    valid_d = 1'b0;
                    state_d = ST_COOL;
                end else if (ready_i) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    dat_d   = we_q ? '0 : rdata_i;
                    state_d = ST_COOL;
                end else if (cnt_tc) begin
                    valid_d   = 1'b0;
                    ack_d     = 1'b1;
                    dat_d     = ERR_DATA;
                    timeout_d = 1'b1;
                    state_d   = ST_COOL;
                end
            end
            ST_COOL: begin
                // Registered peripheral ready lingers here for one cycle; ignore it.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            wstrb_q   <= 4'b0000;
            wdata_q   <= '0;
            adr_q     <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            we_q      <= we_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            adr_q     <= adr_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            timeout_q <= timeout_d;
        end
    end

    assign valid_o   = valid_q;
    assign wbs_we_o  = we_q;
    assign wstrb_o   = wstrb_q;
    assign wdata_o   = wdata_q;
    assign adr_o     = adr_q;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_native_bridge.sv
// Bench for wb_native_bridge: vector table, hand-written corner sequences and
// randomized transfers against a transaction-level model, with a registered-ready peripheral.
module tb_wb_native_bridge;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        valid_o, wbs_we_o;
    logic [3:0]  wstrb_o;
    logic [31:0] wdata_o, adr_o;
    logic        ready_i;
    logic [31:0] rdata_i;
    logic        timeout_o;

    wb_native_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .valid_o   (valid_o),
        .wbs_we_o  (wbs_we_o),
        .wstrb_o   (wstrb_o),
        .wdata_o   (wdata_o),
        .adr_o     (adr_o),
        .ready_i   (ready_i),
        .rdata_i   (rdata_i),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Peripheral with a registered ready: answers resp_delay cycles after valid
    // is first seen, and its ready lingers one cycle after valid drops.
    logic        resp_en    = 1'b0;
    int          resp_delay = 0;
    logic [31:0] resp_data  = 32'h0;
    int          vrun;
    logic        ready_r;
    logic [31:0] rdata_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vrun    <= 0;
            ready_r <= 1'b0;
            rdata_r <= 32'h0;
        end else begin
            vrun    <= valid_o ? vrun + 1 : 0;
            ready_r <= valid_o && resp_en && (vrun >= resp_delay);
            rdata_r <= resp_data;
        end
    end

    assign ready_i = ready_r;
    assign rdata_i = ready_r ? rdata_r : 32'h0;

    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (wbs_ack_o) check("ack_single_cycle", {31'b0, prev_ack}, 32'h0);
        prev_ack <= wbs_ack_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One Wishbone transfer started from the current cycle; cycle 1 is the one
    // after the first edge at which stb is presented.
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, output int ack_c, output int vcnt,
                        output int first_v, output logic [31:0] adr_s,
                        output logic [3:0] wstrb_s, output logic [31:0] wdata_s,
                        output logic we_s);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
        ack_c = -1; vcnt = 0; first_v = -1;
        adr_s = 32'h0; wstrb_s = 4'h0; wdata_s = 32'h0; we_s = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (valid_o) begin
                if (first_v < 0) begin
                    first_v = c; adr_s = adr_o; wstrb_s = wstrb_o;
                    wdata_s = wdata_o; we_s = wbs_we_o;
                end
                vcnt++;
            end
            if (wbs_ack_o) begin
                ack_c = c;
                break;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    endtask

    task automatic idle(input int n, input string name);
        int stray;
        stray = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (valid_o || wbs_ack_o) stray++;
        end
        check(name, stray, 0);
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_valid"},   {31'b0, valid_o},   32'h0);
        check({p, "_ack"},     {31'b0, wbs_ack_o}, 32'h0);
        check({p, "_dat_o"},   wbs_dat_o,          32'h0);
        check({p, "_we_o"},    {31'b0, wbs_we_o},  32'h0);
        check({p, "_wstrb"},   {28'b0, wstrb_o},   32'h0);
        check({p, "_wdata"},   wdata_o,            32'h0);
        check({p, "_adr"},     adr_o,              32'h0);
        check({p, "_timeout"}, {31'b0, timeout_o}, 32'h0);
    endtask

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        resp;
        int          dly;
        logic [31:0] pdata;
        int          exp_ack;
        logic [31:0] exp_rd;
        int          exp_vcnt;
        logic        exp_tmo;
    } vec_t;

    vec_t        vecs[8];
    int          ack_c, vcnt, first_v;
    logic [31:0] adr_s, wdata_s, last_rd, e_rd, adr_r, dat_r, held;
    logic [3:0]  wstrb_s, sel_r;
    logic        we_s, tmo_m, inwin, we_r, resp_r, ok;
    int          dly_r, e_ack, e_v;

    initial begin
        vecs[0] = '{32'h3000_0000, 1'b0, 4'hF, 32'h0000_0000, 1'b1, 0,  32'h0000_002A, 3,  32'h0000_002A, 2,  1'b0};
        vecs[1] = '{32'h3000_0010, 1'b1, 4'h3, 32'h1234_5678, 1'b1, 0,  32'hFFFF_FFFF, 3,  32'h0000_0000, 2,  1'b0};
        vecs[2] = '{32'h300F_FFFC, 1'b0, 4'hF, 32'h0000_0000, 1'b0, 0,  32'h0000_0000, 17, 32'hDEAD_BEEF, 16, 1'b1};
        vecs[3] = '{32'h3000_0004, 1'b0, 4'hF, 32'h0000_0000, 1'b1, 2,  32'hA5A5_0001, 5,  32'hA5A5_0001, 4,  1'b1};
        vecs[4] = '{32'h2000_0000, 1'b0, 4'hF, 32'h0000_0000, 1'b1, 0,  32'h7777_7777, -1, 32'hA5A5_0001, 0,  1'b1};
        vecs[5] = '{32'h3000_0100, 1'b0, 4'hF, 32'h0000_0000, 1'b1, 14, 32'h0BAD_CAFE, 17, 32'h0BAD_CAFE, 16, 1'b1};
        vecs[6] = '{32'h3000_0104, 1'b0, 4'hF, 32'h0000_0000, 1'b1, 15, 32'h1357_9BDF, 17, 32'hDEAD_BEEF, 16, 1'b1};
        vecs[7] = '{32'h3008_0008, 1'b1, 4'h8, 32'hFEED_0042, 1'b1, 3,  32'h2468_ACE0, 6,  32'h0000_0000, 5,  1'b1};

        rst_n = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("after_reset");

        for (int i = 0; i < 8; i++) begin
            resp_en = vecs[i].resp; resp_delay = vecs[i].dly; resp_data = vecs[i].pdata;
            xfer(vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].dat,
                 ack_c, vcnt, first_v, adr_s, wstrb_s, wdata_s, we_s);
            check($sformatf("v%0d_ack_cycle", i), ack_c, vecs[i].exp_ack);
            check($sformatf("v%0d_valid_cycles", i), vcnt, vecs[i].exp_vcnt);
            check($sformatf("v%0d_dat_o", i), wbs_dat_o, vecs[i].exp_rd);
            check($sformatf("v%0d_timeout", i), {31'b0, timeout_o}, {31'b0, vecs[i].exp_tmo});
            if (vecs[i].exp_vcnt > 0) begin
                check($sformatf("v%0d_adr_o", i), adr_s, vecs[i].adr);
                check($sformatf("v%0d_we_o", i), {31'b0, we_s}, {31'b0, vecs[i].we});
                check($sformatf("v%0d_wstrb", i), {28'b0, wstrb_s},
                      {28'b0, (vecs[i].we ? vecs[i].sel : 4'h0)});
                check($sformatf("v%0d_wdata", i), wdata_s, vecs[i].dat);
            end
            idle(3, $sformatf("v%0d_no_stray", i));
            tmo_m   = vecs[i].exp_tmo;
            last_rd = vecs[i].exp_rd;
        end

        // Back-to-back reads: second stb is already up during the cool-down cycle.
        resp_en = 1'b1; resp_delay = 0; resp_data = 32'h1111_0001;
        xfer(32'h3000_0200, 1'b0, 4'hF, 32'h0, ack_c, vcnt, first_v, adr_s, wstrb_s, wdata_s, we_s);
        check("b2b_first_ack", ack_c, 3);
        check("b2b_first_dat", wbs_dat_o, 32'h1111_0001);
        resp_data = 32'h2222_0002;
        xfer(32'h3000_0204, 1'b0, 4'hF, 32'h0, ack_c, vcnt, first_v, adr_s, wstrb_s, wdata_s, we_s);
        check("b2b_second_valid_rise", first_v, 2);
        check("b2b_second_ack", ack_c, 4);
        check("b2b_second_dat", wbs_dat_o, 32'h2222_0002);
        idle(3, "b2b_no_stray");

        // Master abort in the same cycle ready rises.
        held = wbs_dat_o;
        resp_en = 1'b1; resp_delay = 0; resp_data = 32'h3333_0003;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h3000_0020; wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        check("abort_valid_c1", {31'b0, valid_o}, 32'h1);
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        check("abort_valid_c3", {31'b0, valid_o}, 32'h0);
        check("abort_ack_c3", {31'b0, wbs_ack_o}, 32'h0);
        @(posedge clk); #1;
        check("abort_ack_c4", {31'b0, wbs_ack_o}, 32'h0);
        check("abort_dat_held", wbs_dat_o, held);
        resp_data = 32'h4444_0004;
        xfer(32'h3000_0024, 1'b0, 4'hF, 32'h0, ack_c, vcnt, first_v, adr_s, wstrb_s, wdata_s, we_s);
        check("abort_then_ack", ack_c, 3);
        check("abort_then_dat", wbs_dat_o, 32'h4444_0004);
        idle(2, "abort_no_stray");
        last_rd = 32'h4444_0004;

        // Randomized transfers against a transaction-level model.
        for (int n = 0; n < 60; n++) begin
            inwin  = ($urandom_range(7) != 0);
            we_r   = $urandom_range(1);
            sel_r  = 4'($urandom);
            dat_r  = $urandom;
            resp_r = ($urandom_range(7) != 0);
            dly_r  = $urandom_range(15);
            adr_r  = inwin ? (32'h3000_0000 | ($urandom & 32'h000F_FFFC))
                           : (32'h3010_0000 | ($urandom & 32'h0FEF_FFFC));
            resp_en = resp_r; resp_delay = dly_r; resp_data = $urandom;
            if (inwin) begin
                ok    = resp_r && (dly_r <= T - 2);
                e_ack = ok ? 3 + dly_r : T + 1;
                e_rd  = !ok ? 32'hDEAD_BEEF : (we_r ? 32'h0 : resp_data);
                e_v   = e_ack - 1;
                if (!ok) tmo_m = 1'b1;
            end else begin
                e_ack = -1;
                e_rd  = last_rd;
                e_v   = 0;
            end
            last_rd = e_rd;
            xfer(adr_r, we_r, sel_r, dat_r, ack_c, vcnt, first_v, adr_s, wstrb_s, wdata_s, we_s);
            check($sformatf("r%0d_ack_cycle", n), ack_c, e_ack);
            check($sformatf("r%0d_valid_cycles", n), vcnt, e_v);
            check($sformatf("r%0d_dat_o", n), wbs_dat_o, e_rd);
            check($sformatf("r%0d_timeout", n), {31'b0, timeout_o}, {31'b0, tmo_m});
            if (inwin) begin
                check($sformatf("r%0d_adr_o", n), adr_s, adr_r);
                check($sformatf("r%0d_wstrb", n), {28'b0, wstrb_s}, {28'b0, (we_r ? sel_r : 4'h0)});
                check($sformatf("r%0d_wdata", n), wdata_s, dat_r);
            end
            idle($urandom_range(1, 3), $sformatf("r%0d_no_stray", n));
        end

        // Asynchronous reset in the middle of a request.
        resp_en = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0040; wbs_dat_i = 32'hCAFE_F00D;
        @(posedge clk); #1;
        check("rst_pre_valid", {31'b0, valid_o}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        idle(4, "post_rst_no_stray");
        check("post_rst_timeout", {31'b0, timeout_o}, 32'h0);
        resp_en = 1'b1; resp_delay = 1; resp_data = 32'h5555_0005;
        xfer(32'h3000_0044, 1'b0, 4'hF, 32'h0, ack_c, vcnt, first_v, adr_s, wstrb_s, wdata_s, we_s);
        check("post_rst_ack", ack_c, 4);
        check("post_rst_dat", wbs_dat_o, 32'h5555_0005);
        idle(2, "final_no_stray");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
